// File: rtl/pipeline_latch_ctrl.sv
// Pipeline latch sequencer: decodes per-stage write/flush enables from the hazard inputs
// and a small RUN/MEM_WAIT/FLUSH/HALT state machine, with saturating stall/flush counters.
module pipeline_latch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 load_use,
  input  logic                 br_mispredict,
  input  logic                 mem_busy,
  input  logic                 halt_req,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_write,
  output logic                 ex_mem_write,
  output logic                 mem_wb_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);
  localparam logic [FCW-1:0] FCNT_ONE   = FCW'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [FCW-1:0]       fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  // Write enables ordered {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [4:0] wr_s;
  logic       if_flush_s;
  logic       id_flush_s;
  logic       take_br_s;
  logic       stall_ev_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}})) begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Next-state and enable decode; mem_busy > br_mispredict > halt_req > load_use
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    wr_s       = 5'b00000;
    if_flush_s = 1'b0;
    id_flush_s = 1'b0;
    take_br_s  = 1'b0;
    case (state_q)
      S_HALT: begin
        state_d = S_HALT;
      end
      S_FLUSH: begin
        if (mem_busy) begin
          state_d = S_FLUSH;
        end else if (br_mispredict) begin
          take_br_s = 1'b1;
        end else begin
          wr_s       = 5'b11111;
          if_flush_s = 1'b1;
          fcnt_d     = fcnt_q - FCNT_ONE;
          state_d    = (fcnt_q <= FCNT_ONE) ? S_RUN : S_FLUSH;
        end
      end
      S_RUN, S_MEM_WAIT: begin
        if (mem_busy) begin
          state_d = S_MEM_WAIT;
        end else if (br_mispredict) begin
          take_br_s = 1'b1;
        end else if (halt_req) begin
          wr_s    = 5'b00001;
          state_d = S_HALT;
        end else if (load_use) begin
          wr_s       = 5'b00111;
          id_flush_s = 1'b1;
          state_d    = S_RUN;
        end else begin
          wr_s    = 5'b11111;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        fcnt_d  = {FCW{1'b0}};
      end
    endcase

    // Accepted mispredict: redirect PC, squash both front latches, arm the flush window
    if (take_br_s) begin
      wr_s       = 5'b11111;
      if_flush_s = 1'b1;
      id_flush_s = 1'b1;
      fcnt_d     = FLUSH_INIT;
      state_d    = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
    end else begin
      fcnt_d = fcnt_d;
    end

    stall_ev_s = (!wr_s[4]) && (state_q != S_HALT);
  end

  // State, flush window counter and saturating perf counters
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= S_RUN;
      fcnt_q  <= {FCW{1'b0}};
      stall_q <= {CNT_WIDTH{1'b0}};
      flush_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= sat_inc(stall_q, stall_ev_s);
      flush_q <= sat_inc(flush_q, take_br_s);
    end
  end

  // Enables are forced low while reset is asserted
  assign pc_write     = Reset_N & wr_s[4];
  assign if_id_write  = Reset_N & wr_s[3];
  assign id_ex_write  = Reset_N & wr_s[2];
  assign ex_mem_write = Reset_N & wr_s[1];
  assign mem_wb_write = Reset_N & wr_s[0];
  assign if_id_flush  = Reset_N & if_flush_s;
  assign id_ex_flush  = Reset_N & id_flush_s;
  assign halted       = (state_q == S_HALT);
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipeline_latch_ctrl.sv
// Bench for pipeline_latch_ctrl: directed scenarios pinned with literal values, then random
// hazard traffic compared every cycle against a remaining-flush/halt-flag reference model.
module tb_pipeline_latch_ctrl;
  localparam int FC = 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset_N, load_use, br_mispredict, mem_busy, halt_req;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic pc_write4, if_id_write4, id_ex_write4, ex_mem_write4, mem_wb_write4;
  logic if_id_flush4, id_ex_flush4, halted4;
  logic [3:0] stall_cnt4, flush_cnt4;

  pipeline_latch_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(16)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .load_use(load_use), .br_mispredict(br_mispredict),
    .mem_busy(mem_busy), .halt_req(halt_req), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_latch_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(4)) dut4 (
    .Clk(Clk), .Reset_N(Reset_N), .load_use(load_use), .br_mispredict(br_mispredict),
    .mem_busy(mem_busy), .halt_req(halt_req), .pc_write(pc_write4), .if_id_write(if_id_write4),
    .id_ex_write(id_ex_write4), .ex_mem_write(ex_mem_write4), .mem_wb_write(mem_wb_write4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .halted(halted4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  int checks = 0;
  int failures = 0;

  // Reference model: halted flag, remaining squash cycles, raw event counts
  bit m_halted = 1'b0;
  int m_flush_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb,if_flush,id_flush,halted} for this cycle, then advance
  task automatic eval();
    logic [7:0] e;
    bit stall_inc, flush_inc, halt_next;
    int left_next;
    stall_inc = 1'b0; flush_inc = 1'b0; halt_next = m_halted; left_next = m_flush_left;
    if (!Reset_N) begin
      m_halted = 1'b0; m_flush_left = 0; m_stall = 0; m_flush = 0;
      halt_next = 1'b0; left_next = 0;
      e = 8'b00000_00_0;
    end else if (m_halted) begin
      e = 8'b00000_00_1;
    end else if (mem_busy) begin
      e = 8'b00000_00_0; stall_inc = 1'b1;
    end else if (br_mispredict) begin
      e = 8'b11111_11_0; flush_inc = 1'b1; left_next = FC - 1;
    end else if (m_flush_left > 0) begin
      e = 8'b11111_10_0; left_next = m_flush_left - 1;
    end else if (halt_req) begin
      e = 8'b00001_00_0; stall_inc = 1'b1; halt_next = 1'b1;
    end else if (load_use) begin
      e = 8'b00111_01_0; stall_inc = 1'b1;
    end else begin
      e = 8'b11111_00_0;
    end
    cmp("outputs", {24'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                    if_id_flush, id_ex_flush, halted}, {24'd0, e});
    cmp("outputs_w4", {24'd0, pc_write4, if_id_write4, id_ex_write4, ex_mem_write4, mem_wb_write4,
                       if_id_flush4, id_ex_flush4, halted4}, {24'd0, e});
    cmp("stall_cnt", {16'd0, stall_cnt}, sat(m_stall, 16));
    cmp("flush_cnt", {16'd0, flush_cnt}, sat(m_flush, 16));
    cmp("stall_cnt_w4", {28'd0, stall_cnt4}, sat(m_stall, 4));
    cmp("flush_cnt_w4", {28'd0, flush_cnt4}, sat(m_flush, 4));
    if (Reset_N) begin
      m_stall += int'(stall_inc);
      m_flush += int'(flush_inc);
      m_halted = halt_next;
      m_flush_left = left_next;
    end
  endtask

  task automatic drive(input bit r, input bit lu, input bit br, input bit mb, input bit hr);
    @(posedge Clk);
    #1;
    Reset_N = r; load_use = lu; br_mispredict = br; mem_busy = mb; halt_req = hr;
    @(negedge Clk);
    eval();
  endtask

  initial begin
    Reset_N = 1'b0; load_use = 1'b0; br_mispredict = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset_pc_write", {31'd0, pc_write}, 32'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("idle_pc_write", {31'd0, pc_write}, 32'd1);
    cmp("idle_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    cmp("idle_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cmp("lu_enables", {27'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 32'h07);
    cmp("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cmp("mb_frozen", {27'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 32'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("br_flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("flush_state_flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("back_to_run_flushes", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
    cmp("mb_br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    cmp("mb_br_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("br_beats_lu_pc", {31'd0, pc_write}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("br_lu_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    cmp("br_lu_flush_cnt", {16'd0, flush_cnt}, 32'd2);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("halt_enables", {27'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 32'h01);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("halted", {31'd0, halted}, 32'd1);
    cmp("halt_enables_off", {27'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 32'h00);
    cmp("halt_stall_cnt", {16'd0, stall_cnt}, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("post_reset_halted", {31'd0, halted}, 32'd0);
    cmp("post_reset_pc", {31'd0, pc_write}, 32'd1);

    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("sat_stall_cnt_w4", {28'd0, stall_cnt4}, 32'd15);
    cmp("sat_stall_cnt_w16", {16'd0, stall_cnt}, 32'd20);

    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset_mid_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset_aborts_flush", {31'd0, if_id_flush}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) >= 2), ($urandom_range(99) < 25), ($urandom_range(99) < 15),
            ($urandom_range(99) < 20), ($urandom_range(99) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
